// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the register file: one holding entry each for the
// execute and load writeback sources, a registered write port and a busy map.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  output logic        ex_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_waddr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ready,
  output logic        rf_reg_wr,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic          r_ex_v;
  logic [4:0]    r_ex_a;
  logic [31:0]   r_ex_d;
  logic          r_ld_v;
  logic [4:0]    r_ld_a;
  logic [31:0]   r_ld_d;
  // Age tag: 1 when the ex entry was accepted no later than the ld entry.
  logic          r_ex_older;
  logic [SW-1:0] r_starve;
  logic          r_wr;
  logic [4:0]    r_wa;
  logic [31:0]   r_wd;

  logic          w_grant_ex;
  logic          w_grant_ld;
  logic          w_ex_load;
  logic          w_ld_load;
  logic [31:0]   w_busy;

  // Grant depends only on held state, never on the incoming valids.
  always_comb begin
    w_grant_ex = 1'b0;
    w_grant_ld = 1'b0;
    if (r_ex_v && r_ld_v) begin
      if (r_ex_a == r_ld_a) w_grant_ex = r_ex_older;
      else                  w_grant_ex = (r_starve == LIMIT);
      w_grant_ld = !w_grant_ex;
    end else begin
      w_grant_ex = r_ex_v;
      w_grant_ld = r_ld_v;
    end
  end

  // Handshake: a write transfers at a rising edge when x_valid and x_ready are
  // both high; ready means the entry is empty or is being drained this cycle.
  assign ex_ready  = reset & (!r_ex_v | w_grant_ex);
  assign ld_ready  = reset & (!r_ld_v | w_grant_ld);
  // Writes to x0 complete the handshake but are dropped here.
  assign w_ex_load = ex_valid & ex_ready & (ex_waddr != 5'd0);
  assign w_ld_load = ld_valid & ld_ready & (ld_waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_v     <= 1'b0;
      r_ld_v     <= 1'b0;
      r_ex_older <= 1'b1;
      r_starve   <= '0;
      r_wr       <= 1'b0;
      r_wa       <= 5'd0;
      r_wd       <= 32'd0;
    end else begin
      if (w_ex_load) begin
        r_ex_v <= 1'b1;
        r_ex_a <= ex_waddr;
        r_ex_d <= ex_wdata;
      end else if (w_grant_ex) begin
        r_ex_v <= 1'b0;
      end
      if (w_ld_load) begin
        r_ld_v <= 1'b1;
        r_ld_a <= ld_waddr;
        r_ld_d <= ld_wdata;
      end else if (w_grant_ld) begin
        r_ld_v <= 1'b0;
      end
      // Same-edge arrivals count ex as older so the ld value lands last.
      if (w_ex_load && !w_ld_load)      r_ex_older <= 1'b0;
      else if (w_ld_load)               r_ex_older <= 1'b1;

      if (r_ex_v && !w_grant_ex) begin
        if (r_starve != LIMIT) r_starve <= r_starve + 1'b1;
      end else begin
        r_starve <= '0;
      end

      r_wr <= w_grant_ex | w_grant_ld;
      if (w_grant_ex) begin
        r_wa <= r_ex_a;
        r_wd <= r_ex_d;
      end else if (w_grant_ld) begin
        r_wa <= r_ld_a;
        r_wd <= r_ld_d;
      end
    end
  end

  always_comb begin
    w_busy = 32'd0;
    if (r_ex_v) w_busy[r_ex_a] = 1'b1;
    if (r_ld_v) w_busy[r_ld_a] = 1'b1;
    if (r_wr)   w_busy[r_wa]   = 1'b1;
    w_busy[0] = 1'b0;
  end

  assign rf_reg_wr = r_wr;
  assign rf_waddr  = r_wa;
  assign rf_wdata  = r_wd;
  assign busy      = w_busy;

endmodule
